// File: rtl/alu_issue_ctrl_if.sv
// Command and result handshake bundle for alu_issue_ctrl.
// master = command producer / result consumer, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_kind;
    logic [2:0]       cmd_opc;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_w;
    logic             res_zer;
    logic             res_neg;

    modport master (
        output cmd_valid, cmd_kind, cmd_opc, cmd_data, cmd_cin, res_ready,
        input  cmd_ready, res_valid, res_w, res_zer, res_neg
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_opc, cmd_data, cmd_cin, res_ready,
        output cmd_ready, res_valid, res_w, res_zer, res_neg
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequential front-end for a combinational 16-bit ALU: accumulator, registered
// operand issue, one-cycle result capture and a valid/ready result port.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus,
    output logic [2:0]       alu_opc,
    output logic [WIDTH-1:0] alu_ina,
    output logic [WIDTH-1:0] alu_inb,
    output logic             alu_inc,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_cnt
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_LOADA   = 2'b00,
        K_EXEC    = 2'b01,
        K_EXEC_WB = 2'b10,
        K_CLEAR   = 2'b11
    } cmd_kind_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [2:0]       alu_opc_q, alu_opc_d;
    logic [WIDTH-1:0] alu_ina_q, alu_ina_d;
    logic [WIDTH-1:0] alu_inb_q, alu_inb_d;
    logic             alu_inc_q, alu_inc_d;
    logic             wb_q,      wb_d;
    logic [WIDTH-1:0] res_w_q,   res_w_d;
    logic             res_zer_q, res_zer_d;
    logic             res_neg_q, res_neg_d;
    logic [CNT_W-1:0] op_cnt_q,  op_cnt_d;
    cmd_kind_t        kind;

    assign kind = cmd_kind_t'(bus.cmd_kind);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        alu_opc_d = alu_opc_q;
        alu_ina_d = alu_ina_q;
        alu_inb_d = alu_inb_q;
        alu_inc_d = alu_inc_q;
        wb_d      = wb_q;
        res_w_d   = res_w_q;
        res_zer_d = res_zer_q;
        res_neg_d = res_neg_q;
        op_cnt_d  = op_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    unique case (kind)
                        K_LOADA: acc_d = bus.cmd_data;
                        K_CLEAR: acc_d = '0;
                        K_EXEC, K_EXEC_WB: begin
                            alu_opc_d = bus.cmd_opc;
                            alu_ina_d = acc_q;
                            alu_inb_d = bus.cmd_data;
                            alu_inc_d = bus.cmd_cin;
                            wb_d      = (kind == K_EXEC_WB);
                            state_d   = S_ISSUE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            // Operands have been stable for a whole cycle before the capture edge.
            S_ISSUE: state_d = S_CAPT;
            S_CAPT: begin
                res_w_d   = alu_w;
                res_zer_d = alu_zer;
                res_neg_d = alu_neg;
                if (wb_q) begin
                    acc_d = alu_w;
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    op_cnt_d = op_cnt_q + CNT_W'(1);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            alu_opc_q <= '0;
            alu_ina_q <= '0;
            alu_inb_q <= '0;
            alu_inc_q <= 1'b0;
            wb_q      <= 1'b0;
            res_w_q   <= '0;
            res_zer_q <= 1'b0;
            res_neg_q <= 1'b0;
            op_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            alu_opc_q <= alu_opc_d;
            alu_ina_q <= alu_ina_d;
            alu_inb_q <= alu_inb_d;
            alu_inc_q <= alu_inc_d;
            wb_q      <= wb_d;
            res_w_q   <= res_w_d;
            res_zer_q <= res_zer_d;
            res_neg_q <= res_neg_d;
            op_cnt_q  <= op_cnt_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_HOLD);
    assign bus.res_w     = res_w_q;
    assign bus.res_zer   = res_zer_q;
    assign bus.res_neg   = res_neg_q;
    assign alu_opc       = alu_opc_q;
    assign alu_ina       = alu_ina_q;
    assign alu_inb       = alu_inb_q;
    assign alu_inc       = alu_inc_q;
    assign acc           = acc_q;
    assign op_cnt        = op_cnt_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural ALU
// and an accumulator/counter reference model.
module tb_alu_issue_ctrl;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [2:0]       alu_opc;
    logic [WIDTH-1:0] alu_ina;
    logic [WIDTH-1:0] alu_inb;
    logic             alu_inc;
    logic [WIDTH-1:0] alu_w;
    logic             alu_zer;
    logic             alu_neg;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] op_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] m_acc    = '0;
    int unsigned m_cnt    = 0;

    alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .alu_opc (alu_opc),
        .alu_ina (alu_ina),
        .alu_inb (alu_inb),
        .alu_inc (alu_inc),
        .alu_w   (alu_w),
        .alu_zer (alu_zer),
        .alu_neg (alu_neg),
        .acc     (acc),
        .op_cnt  (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {neg, zer, w}.
    function automatic logic [17:0] alu_fn(input logic [2:0] opc, input logic [15:0] a,
                                           input logic [15:0] b, input logic c);
        logic [15:0] w;
        case (opc)
            3'd0:    w = a + b + {15'd0, c};
            3'd1:    w = a - b - {15'd0, c};
            3'd2:    w = a & b;
            3'd3:    w = a | b;
            3'd4:    w = a ^ b;
            3'd5:    w = ~a;
            3'd6:    w = {a[14:0], c};
            default: w = b;
        endcase
        return {w[15], (w == 16'd0), w};
    endfunction

    assign {alu_neg, alu_zer, alu_w} = alu_fn(alu_opc, alu_ina, alu_inb, alu_inc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_simple(input logic [1:0] kind, input logic [15:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_kind  = kind;
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
        m_acc = (kind == 2'b11) ? 16'd0 : data;
        check("simple_acc", 32'(acc), 32'(m_acc));
        check("simple_no_res", 32'(bus.res_valid), 32'd0);
    endtask

    task automatic do_exec(input logic wb, input logic [2:0] opc, input logic [15:0] data,
                           input logic cin, input int unsigned hold);
        logic [17:0] exp_r;
        logic [15:0] held_w;
        int unsigned lat;
        exp_r         = alu_fn(opc, m_acc, data, cin);
        bus.res_ready = (hold == 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_kind  = wb ? 2'b10 : 2'b01;
        bus.cmd_opc   = opc;
        bus.cmd_data  = data;
        bus.cmd_cin   = cin;
        tick();
        bus.cmd_valid = 1'b0;
        check("issue_ops", {alu_ina, alu_inb}, {m_acc, data});
        check("issue_ctl", {28'd0, alu_opc, alu_inc}, {28'd0, opc, cin});
        lat = 1;
        while (!bus.res_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, 32'd3);
        if (wb) m_acc = exp_r[15:0];
        check("res_w", 32'(bus.res_w), 32'(exp_r[15:0]));
        check("res_flags", {30'd0, bus.res_neg, bus.res_zer}, {30'd0, exp_r[17:16]});
        check("acc_after_capt", 32'(acc), 32'(m_acc));
        held_w = bus.res_w;
        for (int i = 0; i < int'(hold); i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_kind  = 2'($urandom_range(0, 3));
            bus.cmd_data  = 16'($urandom);
            tick();
            check("bp_hold", {bus.res_valid, bus.cmd_ready, bus.res_neg, bus.res_zer, bus.res_w},
                  {1'b1, 1'b0, exp_r[17:16], held_w});
            check("bp_acc", 32'(acc), 32'(m_acc));
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        m_cnt++;
        check("op_cnt", 32'(op_cnt), m_cnt % 256);
        check("back_idle", {30'd0, bus.cmd_ready, bus.res_valid}, 32'd2);
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, {bus.cmd_ready, bus.res_valid, bus.res_zer, bus.res_neg, alu_inc},
              {1'b1, 4'd0});
        check({tag, "_regs"}, {acc, op_cnt, alu_opc} | {alu_ina, 11'd0} | {alu_inb, 11'd0}
              | {bus.res_w, 11'd0}, 32'd0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = '0;
        bus.cmd_opc   = '0;
        bus.cmd_data  = '0;
        bus.cmd_cin   = 1'b0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_state("reset");

        // LOADA then a plain EXEC
        do_simple(2'b00, 16'h1234);
        do_exec(1'b0, 3'd0, 16'h0001, 1'b0, 0);
        check("acc_kept", 32'(acc), 32'h1234);

        // write-back producing zero, then a negative result
        do_exec(1'b1, 3'd1, 16'h1234, 1'b0, 0);
        check("wb_zero_acc", 32'(acc), 32'd0);
        do_simple(2'b00, 16'h7fff);
        do_exec(1'b1, 3'd0, 16'h0001, 1'b0, 0);
        check("wb_neg_acc", 32'(acc), 32'h8000);
        do_simple(2'b11, 16'hffff);

        // backpressure
        do_simple(2'b00, 16'h00f0);
        do_exec(1'b0, 3'd4, 16'h0ff0, 1'b1, 5);

        // every opcode with random operands, random write-back and stall lengths
        for (int op = 0; op < 8; op++) begin
            for (int rep = 0; rep < 4; rep++) begin
                if ($urandom_range(0, 3) == 0) do_simple(2'b00, 16'($urandom));
                do_exec(1'($urandom_range(0, 1)), 3'(op), 16'($urandom),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
        end

        // drive the counter round to exactly zero
        while ((m_cnt % 256) != 255) begin
            do_exec(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    1'($urandom_range(0, 1)), 0);
        end
        check("cnt_max", 32'(op_cnt), 32'd255);
        do_exec(1'b0, 3'd7, 16'h5a5a, 1'b0, 0);
        check("cnt_wrap", 32'(op_cnt), 32'd0);

        // reset during ISSUE, then during HOLD (with res_ready high to test dominance)
        for (int pass = 0; pass < 2; pass++) begin
            int unsigned stale;
            do_simple(2'b00, 16'hbeef);
            bus.cmd_valid = 1'b1;
            bus.cmd_kind  = 2'b10;
            bus.cmd_opc   = 3'd0;
            bus.cmd_data  = 16'h0101;
            tick();
            bus.cmd_valid = 1'b0;
            if (pass == 1) begin
                tick();
                tick();
                check("pre_rst_hold", 32'(bus.res_valid), 32'd1);
                bus.res_ready = 1'b1;
            end
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            bus.res_ready = 1'b0;
            m_acc = '0;
            m_cnt = 0;
            check_reset_state(pass == 0 ? "rst_issue" : "rst_hold");
            stale = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                stale += 32'(bus.res_valid);
            end
            check("no_stale", stale, 32'd0);
        end
        do_exec(1'b0, 3'd3, 16'h0f0f, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
